uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver for the FPGA UART: 8 data bits, no parity, 1 stop bit, LSB first. It samples the asynchronous `rx` line using a 16x-baud clock enable, validates the start and stop bits, and presents each received byte in a holding register with a ready/clear handshake. It is the receive-side counterpart of the UART transmitter and shares the same baud generator, at the 16x tap.

## Interface
- No parameters. Frame format is fixed at 8N1; oversampling is fixed at 16x.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `clken`  input  1  one-`clk` pulse at 16x the baud rate (oversample tick).
- `rx`  input  1  asynchronous serial line; idle high.
- `rdy_clr`  input  1  consumer acknowledge; clears `rdy` and `overrun`.
- `dout`  output  8  last good received byte.
- `rdy`  output  1  `dout` holds an unread byte.
- `overrun`  output  1  a byte was stored while `rdy` was set (sticky).
- `framing_err`  output  1  one-`clk` pulse when the stop bit samples low.
- `rx_busy`  output  1  high when the state machine is not in IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer, reset to 1, giving `rx_s`. All FSM decisions use `rx_s`.
- **Counters.**
  - 4-bit sample counter `sample`, wrapping 15→0.
  - 3-bit `bitpos`.
  - 8-bit shift/data register.
- **Clock enable.** Every FSM action below happens only on cycles with `clken`=1. With `clken`=0, all state holds.
- **IDLE**
  - If `rx_s`=0: go to START, `sample`<=0.
- **START** (check the middle of the start bit)
  - If `rx_s`=1: false start (glitch). Return to IDLE. No outputs change.
  - Else if `sample`=7: go to DATA, `sample`<=0, `bitpos`<=0.
  - Else: `sample`++.
- **DATA**
  - If `sample`=15: `data[bitpos]`<=`rx_s`, `sample`<=0. If `bitpos`=7, go to STOP; otherwise `bitpos`++.
  - Else: `sample`++.
- **STOP**
  - If `sample`=15: go to IDLE, `sample`<=0.
    - `rx_s`=1: `dout`<=`data` and `rdy`<=1. If `rdy` was already 1 and `rdy_clr` is 0 this cycle, also set `overrun`<=1.
    - `rx_s`=0: pulse `framing_err` for one `clk`. `dout`, `rdy` and `overrun` are unchanged.
  - Else: `sample`++.
- **Byte handshake**
  - `rdy_clr`=1 clears `rdy` and `overrun` on the next edge.
  - If `rdy_clr` coincides with a good-byte store, the store wins: `rdy`=1 and `dout` is the new byte. `overrun` stays 0.
- **Overrun.** On overrun, `dout` is overwritten with the newest byte; the old byte is lost.
- **Line held low.** A permanent low line (break) produces repeated frames ending in `framing_err` pulses. There is no lockup.
- **Illegal state encoding.** Recovers to IDLE on the next `clken`.

## Timing
- **Reset values:**
  - `dout`=0x00, `rdy`=0, `overrun`=0, `framing_err`=0, `rx_busy`=0.
  - Synchronizer flops=1, state=IDLE, `sample`=0, `bitpos`=0, data=0.
- **Reset is asynchronous.** Asserting it mid-frame aborts the frame immediately. No partial byte is delivered.
- **Synchronizer latency.** 2 `clk` from `rx` to `rx_s`.
- **Sample points** (in `clken` ticks after the tick that detects the falling edge):
  - Start bit: checked on ticks 1..8, accepted at tick 8.
  - Data bit n: sampled at tick 8+16·(n+1).
  - Stop bit: sampled at tick 152.
- **Output update.** `rdy`, `dout`, `overrun` and `framing_err` change on the `clk` edge of the stop-sample `clken` tick, and are visible the following cycle.
- **`rx_busy`** rises on the edge of the detecting tick and falls on the edge of the stop-sample tick.
- **Back-to-back frames.** The next start bit is detected on the first `clken` after returning to IDLE, so frames separated by a single stop bit are received without loss.
- **Combinational paths.** None from inputs to outputs.

## Test plan
- **Single byte:** `clken` every 4 `clk`; send 0xA5 at 16 `clken` ticks per bit → `dout`=0xA5, `rdy`=1, `framing_err` never pulses, `overrun`=0. Then `rdy_clr`=1 → `rdy`=0 next cycle.
- **Glitch reject:** `rx` low for 3 `clken` ticks, then high → FSM returns to IDLE, `rdy` stays 0, `rx_busy` drops within 4 ticks, `dout` unchanged.
- **Framing error:** send 0x3C with stop bit low → `framing_err` high for exactly 1 `clk`, `rdy` stays 0, `dout` holds its previous value.
- **Overrun:** send 0x11 then 0x22 back-to-back without `rdy_clr` → after the second stop bit, `dout`=0x22, `rdy`=1, `overrun`=1. Then `rdy_clr` → both cleared.
- **Simultaneous clear:** assert `rdy_clr` on the exact stop-sample cycle of the second byte 0x55 (first byte still pending) → `rdy`=1, `dout`=0x55, `overrun`=0.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0xFF, release, then send 0x0F → all outputs at reset values after the reset; the next frame yields `dout`=0x0F with no error.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, start/stop validation and a
// holding register that the consumer acknowledges with i_rdy_clr.
module uart_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clken,
    input  logic       i_rx,
    input  logic       i_rdy_clr,
    output logic [7:0] o_dout,
    output logic       o_rdy,
    output logic       o_overrun,
    output logic       o_framing_err,
    output logic       o_rx_busy,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic       r_rx_meta;
    logic       r_rx_s;
    state_t     r_state;
    logic [3:0] r_sample;
    logic [2:0] r_bitpos;
    logic [7:0] r_data;
    logic [7:0] r_dout;
    logic       r_rdy;
    logic       r_overrun;
    logic       r_framing_err;

    state_t     w_state_nxt;
    logic [3:0] w_sample_nxt;
    logic [2:0] w_bitpos_nxt;
    logic [7:0] w_data_nxt;
    logic       w_store;
    logic       w_frame_bad;
    logic [7:0] w_dout_nxt;
    logic       w_rdy_nxt;
    logic       w_overrun_nxt;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_bitpos_nxt = r_bitpos;
        w_data_nxt   = r_data;
        w_store      = 1'b0;
        w_frame_bad  = 1'b0;
        if (i_clken) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt  = S_START;
                        w_sample_nxt = 4'd0;
                    end
                end
                S_START: begin
                    // A high line anywhere before mid-start is treated as noise.
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_sample == 4'd7) begin
                        w_state_nxt  = S_DATA;
                        w_sample_nxt = 4'd0;
                        w_bitpos_nxt = 3'd0;
                    end else begin
                        w_sample_nxt = r_sample + 4'd1;
                    end
                end
                S_DATA: begin
                    if (r_sample == 4'd15) begin
                        w_data_nxt[r_bitpos] = r_rx_s;
                        w_sample_nxt         = 4'd0;
                        if (r_bitpos == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bitpos_nxt = r_bitpos + 3'd1;
                        end
                    end else begin
                        w_sample_nxt = r_sample + 4'd1;
                    end
                end
                S_STOP: begin
                    if (r_sample == 4'd15) begin
                        w_state_nxt  = S_IDLE;
                        w_sample_nxt = 4'd0;
                        w_store      = r_rx_s;
                        w_frame_bad  = !r_rx_s;
                    end else begin
                        w_sample_nxt = r_sample + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sample_nxt = 4'd0;
                end
            endcase
        end
    end

    // A store in the same cycle as an acknowledge wins and leaves overrun clear.
    always_comb begin
        w_dout_nxt    = r_dout;
        w_rdy_nxt     = r_rdy;
        w_overrun_nxt = r_overrun;
        if (i_rdy_clr) begin
            w_rdy_nxt     = 1'b0;
            w_overrun_nxt = 1'b0;
        end
        if (w_store) begin
            w_dout_nxt = r_data;
            w_rdy_nxt  = 1'b1;
            if (r_rdy && !i_rdy_clr) begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sample      <= 4'd0;
            r_bitpos      <= 3'd0;
            r_data        <= 8'h00;
            r_dout        <= 8'h00;
            r_rdy         <= 1'b0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sample      <= w_sample_nxt;
            r_bitpos      <= w_bitpos_nxt;
            r_data        <= w_data_nxt;
            r_dout        <= w_dout_nxt;
            r_rdy         <= w_rdy_nxt;
            r_overrun     <= w_overrun_nxt;
            r_framing_err <= w_frame_bad;
        end
    end

    assign o_dout        = r_dout;
    assign o_rdy         = r_rdy;
    assign o_overrun     = r_overrun;
    assign o_framing_err = r_framing_err;
    assign o_rx_busy     = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames
// compared against a byte-level model of the ready/overrun/framing behaviour.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clken = 1'b0;
    logic       rx = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       overrun;
    logic       framing_err;
    logic       rx_busy;
    logic [1:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int fe_count = 0;

    // Frame-level model: what the consumer should see after each frame.
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_rdy = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .i_clken      (clken),
        .i_rx         (rx),
        .i_rdy_clr    (rdy_clr),
        .o_dout       (dout),
        .o_rdy        (rdy),
        .o_overrun    (overrun),
        .o_framing_err(framing_err),
        .o_rx_busy    (rx_busy),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk in every four.
    initial begin : clken_gen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            clken = (c == 0);
            c = (c + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (framing_err === 1'b1) fe_count++;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    // Each bit lasts 64 clk = 16 clken ticks.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        rx = stop_bit;
        repeat (64) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic good, input logic clr_same);
        if (good) begin
            if (clr_same) exp_ovr = 1'b0;
            else if (exp_rdy) exp_ovr = 1'b1;
            exp_rdy  = 1'b1;
            exp_dout = b;
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h want 00", dout); end
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests_run++; if (framing_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %b want 0", framing_err); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int fe0;
        fe0 = fe_count;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL single_dout: got %h want %h", dout, exp_dout); end
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL single_rdy: got %b want 1", rdy); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL single_overrun: got %b want 0", overrun); end
        tests_run++; if (fe_count != fe0) begin tests_failed++; $display("FAIL single_fe: got %0d pulses want 0", fe_count - fe0); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got %b want 0", rx_busy); end
        pulse_clr();
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL single_clr_rdy: got %b want 0", rdy); end
    endtask

    task automatic test_glitch();
        logic dropped;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++; if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_detect: busy got %b want 1", rx_busy); end
        rx = 1'b1;
        dropped = 1'b0;
        for (int k = 0; k < 18 && !dropped; k++) begin
            @(negedge clk);
            if (rx_busy === 1'b0) dropped = 1'b1;
        end
        tests_run++; if (!dropped) begin tests_failed++; $display("FAIL glitch_busy_drop: busy got %b want 0 within 4 ticks", rx_busy); end
        repeat (64) @(negedge clk);
        tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL glitch_rdy: got %b want %b", rdy, exp_rdy); end
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL glitch_dout: got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_framing();
        int fe0;
        fe0 = fe_count;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (64) @(negedge clk);
        tests_run++; if (fe_count - fe0 != 1) begin tests_failed++; $display("FAIL framing_pulse: got %0d clk high want 1", fe_count - fe0); end
        tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL framing_rdy: got %b want %b", rdy, exp_rdy); end
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL framing_dout: got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL overrun_dout: got %h want %h", dout, exp_dout); end
        tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL overrun_rdy: got %b want %b", rdy, exp_rdy); end
        tests_run++; if (overrun !== exp_ovr) begin tests_failed++; $display("FAIL overrun_flag: got %b want %b", overrun, exp_ovr); end
        pulse_clr();
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL overrun_clr_rdy: got %b want 0", rdy); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_clr_flag: got %b want 0", overrun); end
    endtask

    task automatic test_simultaneous_clear();
        logic seen;
        send_frame(8'h33, 1'b1);
        model_frame(8'h33, 1'b1, 1'b0);
        seen = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                // Stop sample lands 152 ticks (608 clk) after the detecting edge.
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    if (rx_busy === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    repeat (607) @(posedge clk);
                    @(negedge clk);
                    rdy_clr = 1'b1;
                    @(negedge clk);
                    rdy_clr = 1'b0;
                end
            end
        join
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL simclr_start: busy got %b want 1", rx_busy); end
        model_frame(8'h55, 1'b1, 1'b1);
        tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL simclr_rdy: got %b want %b", rdy, exp_rdy); end
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL simclr_dout: got %h want %h", dout, exp_dout); end
        tests_run++; if (overrun !== exp_ovr) begin tests_failed++; $display("FAIL simclr_overrun: got %b want %b", overrun, exp_ovr); end
        pulse_clr();
    endtask

    task automatic test_break();
        int fe0;
        fe0 = fe_count;
        rx = 1'b0;
        repeat (1920) @(negedge clk);
        rx = 1'b1;
        tests_run++; if (fe_count - fe0 != 3) begin tests_failed++; $display("FAIL break_pulses: got %0d want 3", fe_count - fe0); end
        repeat (800) @(negedge clk);
        pulse_clr();
        send_frame(8'h96, 1'b1);
        model_frame(8'h96, 1'b1, 1'b0);
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL break_recover_dout: got %h want %h", dout, exp_dout); end
        tests_run++; if (overrun !== exp_ovr) begin tests_failed++; $display("FAIL break_recover_overrun: got %b want %b", overrun, exp_ovr); end
        pulse_clr();
    endtask

    task automatic test_reset_midframe();
        int fe0;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * 64 + 32) @(negedge clk);
                reset = 1'b1;
                exp_rdy = 1'b0;
                exp_ovr = 1'b0;
                exp_dout = 8'h00;
                exp_q.delete();
                #1;
                tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
                tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL rstmid_dout: got %h want 00", dout); end
                tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rdy: got %b want 0", rdy); end
                repeat (4) @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (64) @(negedge clk);
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_partial: rdy got %b want 0", rdy); end
        fe0 = fe_count;
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b0);
        tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL rstmid_next_dout: got %h want %h", dout, exp_dout); end
        tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL rstmid_next_rdy: got %b want %b", rdy, exp_rdy); end
        tests_run++; if (fe_count != fe0) begin tests_failed++; $display("FAIL rstmid_next_fe: got %0d want 0", fe_count - fe0); end
        pulse_clr();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       good;
        int         fe0;
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            fe0  = fe_count;
            send_frame(b, good);
            model_frame(b, good, 1'b0);
            repeat ($urandom_range(8, 40)) @(negedge clk);
            tests_run++; if (dout !== exp_dout) begin tests_failed++; $display("FAIL rand%0d_dout: got %h want %h", n, dout, exp_dout); end
            tests_run++; if (rdy !== exp_rdy) begin tests_failed++; $display("FAIL rand%0d_rdy: got %b want %b", n, rdy, exp_rdy); end
            tests_run++; if (overrun !== exp_ovr) begin tests_failed++; $display("FAIL rand%0d_overrun: got %b want %b", n, overrun, exp_ovr); end
            tests_run++; if (fe_count - fe0 != (good ? 0 : 1)) begin tests_failed++; $display("FAIL rand%0d_fe: got %0d want %0d", n, fe_count - fe0, good ? 0 : 1); end
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun();
        test_simultaneous_clear();
        test_break();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
